// File: rtl/n64adv2_rst_mask_ctrl.sv
// Console reset-button front end: synchronizer, debounce FSM, press/long-press pulses, reset masks.
// Optional long-press video-pipeline reset is built when LONGPRESS_FULLRST_EN is defined.
module n64adv2_rst_mask_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEBOUNCE_LEN  = 60000,
  parameter int unsigned LONGPRESS_LEN = 60000000,
  parameter int unsigned REARM_LEN     = 256
) (
  input  logic       SYS_CLK_i,
  input  logic       nSRST_i,
  input  logic       N64_nRST_i,
  input  logic       mask_video_i,
  input  logic       mask_audio_i,
  output logic [1:0] nRST_Masking_o,
  output logic       rst_event_o,
  output logic       long_press_o,
  output logic       press_active_o
);

  if (SYNC_STAGES < 2 || DEBOUNCE_LEN < 1 || LONGPRESS_LEN < 1 || REARM_LEN < 1)
  begin : gen_param_check
    $error("n64adv2_rst_mask_ctrl: invalid parameter value");
  end

  localparam logic [25:0] CntMax    = '1;
  localparam logic [25:0] DebLast   = 26'(DEBOUNCE_LEN - 1);
  localparam logic [25:0] RearmLast = 26'(REARM_LEN - 1);

  typedef enum logic [2:0] {
    StIdle, StDebPress, StPressed, StLong, StDebRel, StRearm
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   n64_nrst_s;
  logic [25:0]            cnt_q, cnt_d;
  logic                   cnt_clr;
  logic                   rst_event_q, rst_event_d;
  logic [1:0]             mask_q;
  logic                   vid_drop;

`ifdef LONGPRESS_FULLRST_EN
  localparam logic [25:0] LongLast = 26'(LONGPRESS_LEN - 1);

  logic vid_drop_q, vid_drop_d;
  logic long_press_q, long_press_d;
`endif

  assign n64_nrst_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    rst_event_d = 1'b0;
`ifdef LONGPRESS_FULLRST_EN
    long_press_d = 1'b0;
    vid_drop_d   = vid_drop_q;
`endif
    case (state_q)
      StIdle: begin
        if (!n64_nrst_s) state_d = StDebPress;
      end
      StDebPress: begin
        if (n64_nrst_s) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          state_d     = StPressed;
          rst_event_d = 1'b1;
        end
      end
      StPressed: begin
        // Release takes priority over a coincident long-press expiry.
        if (n64_nrst_s) begin
          state_d = StDebRel;
`ifdef LONGPRESS_FULLRST_EN
        end else if (cnt_q == LongLast) begin
          state_d      = StLong;
          long_press_d = 1'b1;
          vid_drop_d   = 1'b1;
`endif
        end
      end
      StLong: begin
        if (n64_nrst_s) state_d = StDebRel;
      end
      StDebRel: begin
        if (!n64_nrst_s) begin
          cnt_clr = 1'b1;
        end else if (cnt_q == DebLast) begin
          state_d = StRearm;
        end
      end
      StRearm: begin
        if (cnt_q == RearmLast) begin
          state_d = StIdle;
`ifdef LONGPRESS_FULLRST_EN
          vid_drop_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Cleared on every state change; saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 26'd1;
    end
  end

  always_ff @(posedge SYS_CLK_i) begin
    if (!nSRST_i) begin
      sync_q      <= '1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      rst_event_q <= 1'b0;
      mask_q      <= 2'b00;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], N64_nRST_i};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_event_q <= rst_event_d;
      mask_q      <= {mask_audio_i, mask_video_i & ~vid_drop};
    end
  end

`ifdef LONGPRESS_FULLRST_EN
  always_ff @(posedge SYS_CLK_i) begin
    if (!nSRST_i) begin
      vid_drop_q   <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      vid_drop_q   <= vid_drop_d;
      long_press_q <= long_press_d;
    end
  end

  assign vid_drop     = vid_drop_q;
  assign long_press_o = long_press_q;
`else
  assign vid_drop     = 1'b0;
  assign long_press_o = 1'b0;
`endif

  assign nRST_Masking_o = mask_q;
  assign rst_event_o    = rst_event_q;
  assign press_active_o = (state_q == StPressed) || (state_q == StLong) ||
                          (state_q == StDebRel);

endmodule

// File: tb/tb_n64adv2_rst_mask_ctrl.sv
// Directed bench for n64adv2_rst_mask_ctrl with short debounce/long-press/rearm lengths.
// Long-press expectations follow LONGPRESS_FULLRST_EN as seen by this file.
module tb_n64adv2_rst_mask_ctrl;

`ifdef LONGPRESS_FULLRST_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_srst;
  logic       n64_nrst;
  logic       mask_video;
  logic       mask_audio;
  logic [1:0] masking;
  logic       rst_event;
  logic       long_press;
  logic       press_active;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  n64adv2_rst_mask_ctrl #(
    .SYNC_STAGES  (2),
    .DEBOUNCE_LEN (4),
    .LONGPRESS_LEN(32),
    .REARM_LEN    (8)
  ) dut (
    .SYS_CLK_i     (clk),
    .nSRST_i       (n_srst),
    .N64_nRST_i    (n64_nrst),
    .mask_video_i  (mask_video),
    .mask_audio_i  (mask_audio),
    .nRST_Masking_o(masking),
    .rst_event_o   (rst_event),
    .long_press_o  (long_press),
    .press_active_o(press_active)
  );

  // Sample #1 after the active edge; inputs change right after sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_srst = 1'b0; n64_nrst = 1'b1; mask_video = 1'b1; mask_audio = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (masking !== 2'b00) begin
        n_err++; $display("FAIL reset_mask k=%0d got=%b exp=00", k, masking);
      end
      n_cmp++;
      if ({rst_event, long_press, press_active} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_pulses k=%0d got=%b exp=000", k, {rst_event, long_press, press_active});
      end
    end
    n_srst = 1'b1;
    tick();
    n_cmp++;
    if (masking !== 2'b11) begin
      n_err++; $display("FAIL reset_release_mask got=%b exp=11", masking);
    end
  endtask

  task automatic test_config();
    mask_video = 1'b0;
    tick();
    n_cmp++;
    if (masking !== 2'b10) begin
      n_err++; $display("FAIL config_video got=%b exp=10", masking);
    end
    mask_audio = 1'b0;
    tick();
    n_cmp++;
    if (masking !== 2'b00) begin
      n_err++; $display("FAIL config_audio got=%b exp=00", masking);
    end
    mask_video = 1'b1; mask_audio = 1'b1;
    tick();
    n_cmp++;
    if (masking !== 2'b11) begin
      n_err++; $display("FAIL config_restore got=%b exp=11", masking);
    end
  endtask

  task automatic test_glitch();
    n64_nrst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_cmp++;
      if ({rst_event, long_press, press_active} !== 3'b000) begin
        n_err++;
        $display("FAIL glitch_pulses k=%0d got=%b exp=000", k, {rst_event, long_press, press_active});
      end
      n_cmp++;
      if (masking !== 2'b11) begin
        n_err++; $display("FAIL glitch_mask k=%0d got=%b exp=11", k, masking);
      end
      if (k == 2) n64_nrst = 1'b1;
    end
  endtask

  task automatic test_short_press();
    logic exp_ev, exp_act;
    n64_nrst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      exp_ev  = (k == 6);
      exp_act = (k >= 6 && k <= 25);
      n_cmp++;
      if (rst_event !== exp_ev) begin
        n_err++; $display("FAIL short_event k=%0d got=%b exp=%b", k, rst_event, exp_ev);
      end
      n_cmp++;
      if (press_active !== exp_act) begin
        n_err++; $display("FAIL short_active k=%0d got=%b exp=%b", k, press_active, exp_act);
      end
      n_cmp++;
      if (long_press !== 1'b0) begin
        n_err++; $display("FAIL short_long k=%0d got=%b exp=0", k, long_press);
      end
      n_cmp++;
      if (masking !== 2'b11) begin
        n_err++; $display("FAIL short_mask k=%0d got=%b exp=11", k, masking);
      end
      if (k == 19) n64_nrst = 1'b1;
    end
  endtask

  task automatic test_long_press();
    logic       exp_ev, exp_long, exp_act;
    logic [1:0] exp_mask;
    n64_nrst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      exp_ev   = (k == 6);
      exp_long = LongEn && (k == 38);
      exp_act  = (k >= 6 && k <= 65);
      exp_mask = {1'b1, ~(LongEn && k >= 39 && k <= 74)};
      n_cmp++;
      if (rst_event !== exp_ev) begin
        n_err++; $display("FAIL long_event k=%0d got=%b exp=%b", k, rst_event, exp_ev);
      end
      n_cmp++;
      if (long_press !== exp_long) begin
        n_err++; $display("FAIL long_pulse k=%0d got=%b exp=%b", k, long_press, exp_long);
      end
      n_cmp++;
      if (press_active !== exp_act) begin
        n_err++; $display("FAIL long_active k=%0d got=%b exp=%b", k, press_active, exp_act);
      end
      n_cmp++;
      if (masking !== exp_mask) begin
        n_err++; $display("FAIL long_mask k=%0d got=%b exp=%b", k, masking, exp_mask);
      end
      if (k == 59) n64_nrst = 1'b1;
    end
  endtask

  task automatic test_bounce_release();
    logic [9:0] bounce;
    logic       exp_ev, exp_long, exp_act, prev_m0;
    logic [1:0] exp_mask;
    int         rises;
    bounce  = 10'b1100110011;  // bit 9 is driven first
    rises   = 0;
    prev_m0 = masking[0];
    n64_nrst = 1'b0;
    for (int k = 0; k < 76; k++) begin
      tick();
      exp_ev   = (k == 6);
      exp_long = LongEn && (k == 38);
      exp_act  = (k >= 6 && k <= 57);
      exp_mask = {1'b1, ~(LongEn && k >= 39 && k <= 66)};
      n_cmp++;
      if (rst_event !== exp_ev) begin
        n_err++; $display("FAIL bounce_event k=%0d got=%b exp=%b", k, rst_event, exp_ev);
      end
      n_cmp++;
      if (long_press !== exp_long) begin
        n_err++; $display("FAIL bounce_long k=%0d got=%b exp=%b", k, long_press, exp_long);
      end
      n_cmp++;
      if (press_active !== exp_act) begin
        n_err++; $display("FAIL bounce_active k=%0d got=%b exp=%b", k, press_active, exp_act);
      end
      n_cmp++;
      if (masking !== exp_mask) begin
        n_err++; $display("FAIL bounce_mask k=%0d got=%b exp=%b", k, masking, exp_mask);
      end
      if (!prev_m0 && masking[0]) rises++;
      prev_m0 = masking[0];
      // Value sampled at edge k+1: low until 45, bounce 45..54, then held high.
      if (k + 1 < 45)      n64_nrst = 1'b0;
      else if (k + 1 < 55) n64_nrst = bounce[9 - (k + 1 - 45)];
      else                 n64_nrst = 1'b1;
    end
    n_cmp++;
    if (rises !== (LongEn ? 1 : 0)) begin
      n_err++; $display("FAIL bounce_restore_count got=%0d exp=%0d", rises, LongEn ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid_press();
    n64_nrst = 1'b0;
    for (int k = 0; k < 45; k++) tick();
    n_cmp++;
    if (press_active !== 1'b1) begin
      n_err++; $display("FAIL midrst_pre_active got=%b exp=1", press_active);
    end
    n_cmp++;
    if (masking !== {1'b1, ~LongEn}) begin
      n_err++; $display("FAIL midrst_pre_mask got=%b exp=%b", masking, {1'b1, ~LongEn});
    end
    n_srst = 1'b0; n64_nrst = 1'b1;
    tick();
    n_cmp++;
    if (masking !== 2'b00) begin
      n_err++; $display("FAIL midrst_mask got=%b exp=00", masking);
    end
    n_cmp++;
    if ({rst_event, long_press, press_active} !== 3'b000) begin
      n_err++;
      $display("FAIL midrst_state got=%b exp=000", {rst_event, long_press, press_active});
    end
    tick(); tick();
    n_srst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (masking !== 2'b11) begin
        n_err++; $display("FAIL midrst_after_mask k=%0d got=%b exp=11", k, masking);
      end
      n_cmp++;
      if ({rst_event, long_press, press_active} !== 3'b000) begin
        n_err++;
        $display("FAIL midrst_after_pulses k=%0d got=%b exp=000", k,
                 {rst_event, long_press, press_active});
      end
    end
  endtask

  initial begin
    n_srst = 1'b0; n64_nrst = 1'b1; mask_video = 1'b1; mask_audio = 1'b1;
    test_reset();
    test_config();
    test_glitch();
    test_short_press();
    test_long_press();
    test_bounce_release();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
